// File: rtl/lc3_pkg.sv
// Shared encodings for the multicycle LC-3 controller: opcodes, FSM states,
// datapath select codes and the bit layout of the packed control word.
package lc3_pkg;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_TRAP = 4'b1111;
   localparam logic [7:0] TRAP_HALT = 8'h25;

   typedef enum logic [4:0] {
      S_FETCH0    = 5'd0,
      S_FETCH1    = 5'd1,
      S_FETCH2    = 5'd2,
      S_DECODE    = 5'd3,
      S_EX_ALU    = 5'd4,
      S_EX_BR     = 5'd5,
      S_EX_JMP    = 5'd6,
      S_EX_LEA    = 5'd7,
      S_LD0       = 5'd8,
      S_LD1       = 5'd9,
      S_LD2       = 5'd10,
      S_ST0       = 5'd11,
      S_ST1       = 5'd12,
      S_ST2       = 5'd13,
      S_STEP_WAIT = 5'd14,
      S_HALT      = 5'd15
   } state_t;

   localparam logic [1:0] ALU_ADD  = 2'd0;
   localparam logic [1:0] ALU_AND  = 2'd1;
   localparam logic [1:0] ALU_NOT  = 2'd2;
   localparam logic [1:0] ALU_PASS = 2'd3;

   localparam logic [1:0] SELPC_INC = 2'd0;
   localparam logic [1:0] SELPC_BUS = 2'd1;
   localparam logic [1:0] SELPC_EAB = 2'd2;
   localparam logic       EAB1_PC   = 1'b0;
   localparam logic [1:0] EAB2_OFF9 = 2'd2;
   localparam logic       MDR_MEM   = 1'b0;
   localparam logic       MDR_BUS   = 1'b1;

   // Control word bit offsets; multi-bit fields are addressed with [OFF +: width].
   localparam int OFF_LD_MAR   = 0;
   localparam int OFF_LD_MDR   = 1;
   localparam int OFF_LD_IR    = 2;
   localparam int OFF_LD_PC    = 3;
   localparam int OFF_REG_WE   = 4;
   localparam int OFF_FLAG_WE  = 5;
   localparam int OFF_MEM_WE   = 6;
   localparam int OFF_ENA_PC   = 7;
   localparam int OFF_ENA_MDR  = 8;
   localparam int OFF_ENA_ALU  = 9;
   localparam int OFF_ENA_MARM = 10;
   localparam int OFF_SEL_PC   = 11;
   localparam int OFF_SEL_EAB1 = 13;
   localparam int OFF_SEL_EAB2 = 14;
   localparam int OFF_SEL_MDR  = 16;
   localparam int OFF_ALU_CTL  = 17;
   localparam int OFF_SEL_IMM  = 19;
   localparam int OFF_SR1      = 20;
   localparam int OFF_SR2      = 23;
   localparam int OFF_DR       = 26;
   localparam int CTL_W        = 29;

   function automatic logic cond_met(input logic [15:0] ir, input logic n, input logic z,
                                     input logic p);
      return (ir[11] & n) | (ir[10] & z) | (ir[9] & p);
   endfunction

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH1) || (s == S_LD1) || (s == S_ST2);
   endfunction

endpackage

// File: rtl/lc3_mem_waiter.sv
// Counts stalled memory cycles and flags a timeout on the last permitted wait cycle,
// so the FSM can leave the access on the following edge; MEM_TIMEOUT=0 never times out.
module lc3_mem_waiter #(
   parameter int MEM_TIMEOUT = 64,
   parameter int TO_W        = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic start_i,
   input  logic mem_req_i,
   input  logic mem_ready_i,
   output logic done_o,
   output logic timeout_o
);

   localparam logic [TO_W-1:0] LAST_WAIT = (MEM_TIMEOUT > 0) ? TO_W'(MEM_TIMEOUT - 1) : '0;

   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            waiting;

   assign waiting   = mem_req_i && !mem_ready_i;
   assign done_o    = mem_req_i && mem_ready_i;
   assign timeout_o = (MEM_TIMEOUT > 0) && waiting && (cnt_q == LAST_WAIT);

   always_comb begin
      cnt_d = cnt_q;
      if (start_i) begin
         cnt_d = '0;
      end else if (waiting && (cnt_q != '1)) begin
         cnt_d = cnt_q + TO_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lc3_mc_controller.sv
// Multicycle LC-3 control FSM: Moore control word per state, stalls in memory states
// until mem_ready, halts with a sticky fault on memory timeout or illegal instruction.
module lc3_mc_controller
   import lc3_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int TO_W        = 7,
   parameter int STEP_MODE   = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [15:0]      ir,
   input  logic             n,
   input  logic             z,
   input  logic             p,
   input  logic             mem_ready,
   input  logic             run,
   output logic [CTL_W-1:0] ctl,
   output logic             mem_req,
   output logic             halted,
   output logic             fault,
   output logic [4:0]       state_o
);

   localparam state_t S_DONE = (STEP_MODE != 0) ? S_STEP_WAIT : S_FETCH0;

   state_t           state_q, state_d;
   logic             fault_q, fault_d;
   logic [CTL_W-1:0] ctl_c;
   logic             mem_req_c;
   logic             mem_start, mem_done, mem_timeout;
   logic [3:0]       opcode;

   assign opcode    = ir[15:12];
   assign mem_start = is_mem_state(state_d) && (state_d != state_q);

   lc3_mem_waiter #(
      .MEM_TIMEOUT(MEM_TIMEOUT),
      .TO_W       (TO_W)
   ) u_waiter (
      .clk        (clk),
      .reset      (reset),
      .start_i    (mem_start),
      .mem_req_i  (mem_req_c),
      .mem_ready_i(mem_ready),
      .done_o     (mem_done),
      .timeout_o  (mem_timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         fault_q <= fault_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      case (state_q)
         S_FETCH0: state_d = S_FETCH1;
         S_FETCH1, S_LD1, S_ST2: begin
            if (mem_timeout) begin
               state_d = S_HALT;
               fault_d = 1'b1;
            end else if (mem_done) begin
               state_d = (state_q == S_FETCH1) ? S_FETCH2 :
                         (state_q == S_LD1)    ? S_LD2    : S_DONE;
            end
         end
         S_FETCH2: state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_ADD, OP_AND, OP_NOT: state_d = S_EX_ALU;
               OP_BR:  state_d = S_EX_BR;
               OP_JMP: state_d = S_EX_JMP;
               OP_LEA: state_d = S_EX_LEA;
               OP_LD:  state_d = S_LD0;
               OP_ST:  state_d = S_ST0;
               OP_TRAP: begin
                  state_d = S_HALT;
                  fault_d = fault_q | (ir[7:0] != TRAP_HALT);
               end
               // RTI, reserved and opcodes this core does not sequence
               default: begin
                  state_d = S_HALT;
                  fault_d = 1'b1;
               end
            endcase
         end
         S_EX_ALU, S_EX_BR, S_EX_JMP, S_EX_LEA, S_LD2: state_d = S_DONE;
         S_LD0:       state_d = S_LD1;
         S_ST0:       state_d = S_ST1;
         S_ST1:       state_d = S_ST2;
         S_STEP_WAIT: if (run) state_d = S_FETCH0;
         S_HALT:      if (run && !fault_q) state_d = S_FETCH0;
         default:     state_d = S_FETCH0;
      endcase
   end

   always_comb begin
      ctl_c     = '0;
      mem_req_c = 1'b0;
      case (state_q)
         S_FETCH0: begin
            ctl_c[OFF_ENA_PC]         = 1'b1;
            ctl_c[OFF_LD_MAR]         = 1'b1;
            ctl_c[OFF_LD_PC]          = 1'b1;
            ctl_c[OFF_SEL_PC +: 2]    = SELPC_INC;
         end
         S_FETCH1, S_LD1: begin
            mem_req_c                 = 1'b1;
            ctl_c[OFF_LD_MDR]         = mem_ready;
            ctl_c[OFF_SEL_MDR]        = MDR_MEM;
         end
         S_FETCH2: begin
            ctl_c[OFF_ENA_MDR]        = 1'b1;
            ctl_c[OFF_LD_IR]          = 1'b1;
         end
         S_EX_ALU: begin
            ctl_c[OFF_ENA_ALU]        = 1'b1;
            ctl_c[OFF_REG_WE]         = 1'b1;
            ctl_c[OFF_FLAG_WE]        = 1'b1;
            ctl_c[OFF_ALU_CTL +: 2]   = (opcode == OP_ADD) ? ALU_ADD :
                                        (opcode == OP_AND) ? ALU_AND : ALU_NOT;
            ctl_c[OFF_SEL_IMM]        = ir[5] && (opcode != OP_NOT);
            ctl_c[OFF_SR1 +: 3]       = ir[8:6];
            ctl_c[OFF_SR2 +: 3]       = ir[2:0];
            ctl_c[OFF_DR +: 3]        = ir[11:9];
         end
         S_EX_BR: begin
            if (cond_met(ir, n, z, p)) begin
               ctl_c[OFF_LD_PC]       = 1'b1;
               ctl_c[OFF_SEL_PC +: 2] = SELPC_EAB;
               ctl_c[OFF_SEL_EAB1]    = EAB1_PC;
               ctl_c[OFF_SEL_EAB2 +: 2] = EAB2_OFF9;
            end
         end
         S_EX_JMP: begin
            ctl_c[OFF_LD_PC]          = 1'b1;
            ctl_c[OFF_SEL_PC +: 2]    = SELPC_BUS;
            ctl_c[OFF_SR1 +: 3]       = ir[8:6];
         end
         S_EX_LEA, S_LD0, S_ST0: begin
            ctl_c[OFF_ENA_MARM]       = 1'b1;
            ctl_c[OFF_SEL_EAB1]       = EAB1_PC;
            ctl_c[OFF_SEL_EAB2 +: 2]  = EAB2_OFF9;
            ctl_c[OFF_LD_MAR]         = (state_q != S_EX_LEA);
            ctl_c[OFF_REG_WE]         = (state_q == S_EX_LEA);
            ctl_c[OFF_FLAG_WE]        = (state_q == S_EX_LEA);
            ctl_c[OFF_DR +: 3]        = (state_q == S_EX_LEA) ? ir[11:9] : 3'd0;
         end
         S_LD2: begin
            ctl_c[OFF_ENA_MDR]        = 1'b1;
            ctl_c[OFF_REG_WE]         = 1'b1;
            ctl_c[OFF_FLAG_WE]        = 1'b1;
            ctl_c[OFF_DR +: 3]        = ir[11:9];
         end
         S_ST1: begin
            ctl_c[OFF_SR1 +: 3]       = ir[11:9];
            ctl_c[OFF_ENA_ALU]        = 1'b1;
            ctl_c[OFF_ALU_CTL +: 2]   = ALU_PASS;
            ctl_c[OFF_LD_MDR]         = 1'b1;
            ctl_c[OFF_SEL_MDR]        = MDR_BUS;
         end
         S_ST2: begin
            mem_req_c                 = 1'b1;
            ctl_c[OFF_MEM_WE]         = 1'b1;
         end
         default: ;
      endcase
   end

   // FETCH0 is the reset state but its loads must not fire while reset is still held.
   assign ctl     = reset ? '0 : ctl_c;
   assign mem_req = mem_req_c;
   assign halted  = (state_q == S_HALT);
   assign fault   = fault_q;
   assign state_o = state_q;

endmodule
